io_port: RTL and testbench
==========================

IO_PORT -- requirements
Module: io_port

Interface
REQ-001 SHALL have parameter WORD_W, default 8, CPU data word width; only WORD_W = 8 is supported.
REQ-002 SHALL have parameter DEBOUNCE_N, default 4, consecutive stable cycles required to accept a switch change.
REQ-003 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port n_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  CPU bus request, held high until ack is seen.
REQ-006 SHALL have port we  input  1  write enable (1 = write, 0 = read), valid while req is high.
REQ-007 SHALL have port addr  input  2  register select: 0 SWITCH (RO), 1 DISP_LO (RW), 2 DISP_HI (RW), 3 STATUS (RO).
REQ-008 SHALL have port wdata  input  WORD_W  write data, valid while req && we.
REQ-009 SHALL have port rdata  output  WORD_W  read data, valid while ack is high.
REQ-010 SHALL have port ack  output  1  one-cycle transfer acknowledge.
REQ-011 SHALL have port switches  input  8  asynchronous board switch inputs.
REQ-012 SHALL have ports disp0, disp1, disp2, disp3  output  7 each  active-low seven-segment outputs, bit order {g,f,e,d,c,b,a}.

Function
REQ-013 SHALL implement responder FSM states IDLE, ACK, WAIT_DROP.
REQ-014 SHALL move IDLE->ACK on the first edge where req = 1, capturing addr, we and wdata at that edge.
REQ-015 SHALL assert ack for exactly one cycle while in ACK, then move ACK->WAIT_DROP unconditionally.
REQ-016 SHALL stay in WAIT_DROP while req = 1 and return to IDLE on the first edge where req = 0; a new transfer therefore needs req low for at least one edge.
REQ-017 SHALL update DISP_LO/DISP_HI with the captured wdata on the IDLE->ACK edge; writes to addresses 0 and 3 SHALL be acknowledged and ignored.
REQ-018 SHALL load rdata on the IDLE->ACK edge and hold it until the next read; writes SHALL leave rdata unchanged.
REQ-019 SHALL return on read: addr 0 debounced switch value; addr 1/2 the register contents; addr 3 {7'b0, changed}.
REQ-020 SHALL pass switches through a 2-flop synchronizer before any other use.
REQ-021 SHALL run a debounce counter: when synchronized value != debounced value, increment; when equal, clear to 0; when the counter reaches DEBOUNCE_N-1 with the values still different, load the debounced value and clear the counter.
REQ-022 SHALL therefore update the debounced value DEBOUNCE_N+2 edges after a stable switch change, measured from the first edge that samples the new value; shorter glitches SHALL be discarded.
REQ-023 SHALL set changed when the debounced value updates and clear it on a read of addr 0; if both occur on the same edge, set SHALL win.
REQ-024 SHALL decode each nibble to a seven-segment pattern: disp0 = DISP_LO[3:0], disp1 = DISP_LO[7:4], disp2 = DISP_HI[3:0], disp3 = DISP_HI[7:4].
REQ-025 SHALL use the hex patterns 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-026 SHALL drive disp outputs combinationally from the registers, so a write is visible on the cycle ack is high.

Reset
REQ-027 SHALL, while n_reset = 0, immediately force: FSM to IDLE, ack 0, rdata 0, DISP_LO/DISP_HI 0 (all disps 1000000), synchronizer, debounced value and counter 0, and changed 0.
REQ-028 SHALL abort an in-flight transfer on reset without applying it; a req still high after reset release SHALL start a fresh transfer.

Verification
REQ-029 SHALL verify write/display: req=1, we=1, addr=1, wdata=8'h3A -> ack high one cycle later for 1 cycle; disp0=0001000, disp1=0110000.
REQ-030 SHALL verify readback: write addr 2 = 8'hC5, then read addr 2 -> rdata=8'hC5 with ack; disp2=0010010, disp3=1000110.
REQ-031 SHALL verify debounce: switches 8'h00->8'h0F held stable with DEBOUNCE_N=4 -> addr 0 reads 8'h0F after 6 edges; STATUS reads 8'h01; a second addr 0 read leaves STATUS at 8'h00.
REQ-032 SHALL verify glitch rejection: switches pulsed to 8'hFF for 2 cycles -> debounced value stays 8'h00 and changed stays 0.
REQ-033 SHALL verify the hold rule: req held high for 5 cycles -> exactly one ack pulse, and no second ack until req drops.
REQ-034 SHALL verify mid-transfer reset: n_reset pulsed low while in ACK after a DISP_LO write of 8'h77 -> disp0..disp3 = 1000000, ack = 0, FSM in IDLE.

Source files
------------

// File: rtl/io_port.sv
// rtl/io_port.sv - CPU-mapped switch input and seven-segment display port
module io_port #(
  parameter int WORD_W     = 8,
  parameter int DEBOUNCE_N = 4
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ack,
  input  logic [7:0]        switches,
  output logic [6:0]        disp0,
  output logic [6:0]        disp1,
  output logic [6:0]        disp2,
  output logic [6:0]        disp3
);

  localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ACK       = 2'd1;
  localparam logic [1:0] S_WAIT_DROP = 2'd2;

  localparam logic [1:0] A_SWITCH  = 2'd0;
  localparam logic [1:0] A_DISP_LO = 2'd1;
  localparam logic [1:0] A_DISP_HI = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  logic [1:0]        r_state;
  logic [WORD_W-1:0] r_rdata;
  logic [WORD_W-1:0] r_disp_lo;
  logic [WORD_W-1:0] r_disp_hi;
  logic [7:0]        r_sync1;
  logic [7:0]        r_sync2;
  logic [7:0]        r_deb;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_changed;

  logic              w_start;
  logic              w_rd_switch;
  logic              w_diff;
  logic              w_deb_load;
  logic [WORD_W-1:0] w_rd_word;

  // A transfer is accepted only from IDLE; all register side effects happen on that edge.
  assign w_start     = (r_state == S_IDLE) && req;
  assign w_rd_switch = w_start && !we && (addr == A_SWITCH);
  assign w_diff      = (r_sync2 != r_deb);
  assign w_deb_load  = w_diff && (r_cnt == CNT_W'(DEBOUNCE_N - 1));

  assign ack   = (r_state == S_ACK);
  assign rdata = r_rdata;

  // Read data selection for the register currently addressed.
  always_comb begin
    w_rd_word = '0;
    case (addr)
      A_SWITCH:  w_rd_word = WORD_W'(r_deb);
      A_DISP_LO: w_rd_word = r_disp_lo;
      A_DISP_HI: w_rd_word = r_disp_hi;
      A_STATUS:  w_rd_word = {{(WORD_W-1){1'b0}}, r_changed};
      default:   w_rd_word = '0;
    endcase
  end

  // Responder FSM: one ack cycle, then wait for req to drop before rearming.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:      if (req) r_state <= S_ACK;
        S_ACK:       r_state <= S_WAIT_DROP;
        S_WAIT_DROP: if (!req) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  // Register writes and read-data capture; rdata holds until the next read.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_rdata   <= '0;
      r_disp_lo <= '0;
      r_disp_hi <= '0;
    end else if (w_start) begin
      if (we) begin
        if (addr == A_DISP_LO) r_disp_lo <= wdata;
        if (addr == A_DISP_HI) r_disp_hi <= wdata;
      end else begin
        r_rdata <= w_rd_word;
      end
    end
  end

  // Two-flop synchronizer followed by a stable-count debouncer.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= switches;
      r_sync2 <= r_sync1;
      if (w_deb_load) begin
        r_deb <= r_sync2;
        r_cnt <= '0;
      end else if (w_diff) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Change flag: set on a debounced update, cleared by reading SWITCH; set wins a tie.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_changed <= 1'b0;
    end else if (w_deb_load) begin
      r_changed <= 1'b1;
    end else if (w_rd_switch) begin
      r_changed <= 1'b0;
    end
  end

  function automatic logic [6:0] f_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Displays follow the registers combinationally so a write shows during its ack.
  always_comb begin
    disp0 = f_seg(r_disp_lo[3:0]);
    disp1 = f_seg(r_disp_lo[7:4]);
    disp2 = f_seg(r_disp_hi[3:0]);
    disp3 = f_seg(r_disp_hi[7:4]);
  end

endmodule

// File: tb/tb_io_port.sv
// tb/tb_io_port.sv - directed self-checking bench for io_port
module tb_io_port;

  logic       clock;
  logic       n_reset;
  logic       req;
  logic       we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ack;
  logic [7:0] switches;
  logic [6:0] disp0, disp1, disp2, disp3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] rd;
  int         lat;
  int         acks;
  logic [6:0] snap_d0, snap_d1, snap_d2, snap_d3;

  localparam logic [6:0] SEG_0 = 7'b1000000;

  io_port #(.WORD_W(8), .DEBOUNCE_N(4)) dut (
    .clock(clock), .n_reset(n_reset), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ack(ack), .switches(switches),
    .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns ack latency in cycles (-1 on timeout) and rdata at ack.
  task automatic bus(input logic w, input logic [1:0] a, input logic [7:0] d,
                     output logic [7:0] r, output int l);
    req = 1'b1; we = w; addr = a; wdata = d;
    l = -1; r = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (ack) begin
        l = i;
        break;
      end
    end
    r = rdata;
    snap_d0 = disp0; snap_d1 = disp1; snap_d2 = disp2; snap_d3 = disp3;
    req = 1'b0; we = 1'b0;
    @(negedge clock);
    check("ack_one_cycle", ack, 0);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset = 1'b0; req = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00; switches = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_disp0", disp0, SEG_0);
    check("rst_disp3", disp3, SEG_0);
    n_reset = 1'b1;
    @(negedge clock);

    // write/display
    bus(1'b1, 2'd1, 8'h3A, rd, lat);
    check("wr_lo_lat", lat, 1);
    check("wr_lo_disp0", snap_d0, 7'b0001000);
    check("wr_lo_disp1", snap_d1, 7'b0110000);

    // readback
    bus(1'b1, 2'd2, 8'hC5, rd, lat);
    check("wr_hi_lat", lat, 1);
    bus(1'b0, 2'd2, 8'h00, rd, lat);
    check("rd_hi_lat", lat, 1);
    check("rd_hi_data", rd, 8'hC5);
    check("disp2", disp2, 7'b0010010);
    check("disp3", disp3, 7'b1000110);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    check("rd_lo_data", rd, 8'h3A);

    // writes to RO addresses are acknowledged, ignored, and leave rdata alone
    bus(1'b1, 2'd0, 8'h55, rd, lat);
    check("wr_sw_lat", lat, 1);
    check("wr_sw_rdata", rd, 8'h3A);
    bus(1'b1, 2'd3, 8'h99, rd, lat);
    check("wr_st_rdata", rd, 8'h3A);
    check("wr_ro_disp0", disp0, 7'b0001000);
    check("wr_ro_disp2", disp2, 7'b0010010);
    bus(1'b0, 2'd3, 8'h00, rd, lat);
    check("status_idle", rd, 8'h00);

    // debounce: read captured on edge 6 sees old value while changed is set (set wins)
    switches = 8'h0F;
    repeat (5) @(negedge clock);
    bus(1'b0, 2'd0, 8'h00, rd, lat);
    check("deb_edge6_old", rd, 8'h00);
    bus(1'b0, 2'd3, 8'h00, rd, lat);
    check("deb_status_set", rd, 8'h01);
    bus(1'b0, 2'd0, 8'h00, rd, lat);
    check("deb_value", rd, 8'h0F);
    bus(1'b0, 2'd3, 8'h00, rd, lat);
    check("deb_status_clr", rd, 8'h00);

    // return switches to zero and clear the flag
    switches = 8'h00;
    repeat (10) @(negedge clock);
    bus(1'b0, 2'd0, 8'h00, rd, lat);
    check("deb_back_zero", rd, 8'h00);

    // glitch rejection
    switches = 8'hFF;
    repeat (2) @(negedge clock);
    switches = 8'h00;
    repeat (10) @(negedge clock);
    bus(1'b0, 2'd0, 8'h00, rd, lat);
    check("glitch_value", rd, 8'h00);
    bus(1'b0, 2'd3, 8'h00, rd, lat);
    check("glitch_status", rd, 8'h00);

    // hold rule
    req = 1'b1; we = 1'b0; addr = 2'd1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (ack) acks++;
    end
    check("hold_acks5", acks, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (ack) acks++;
    end
    check("hold_acks8", acks, 1);
    req = 1'b0;
    repeat (2) @(negedge clock);
    bus(1'b0, 2'd1, 8'h00, rd, lat);
    check("hold_rearm_lat", lat, 1);

    // mid-transfer reset
    req = 1'b1; we = 1'b1; addr = 2'd1; wdata = 8'h77;
    @(negedge clock);
    check("rst_in_ack", ack, 1);
    check("rst_pre_disp0", disp0, 7'b1111000);
    #2 n_reset = 1'b0;
    #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_disp0", disp0, SEG_0);
    check("mid_rst_disp1", disp1, SEG_0);
    check("mid_rst_disp2", disp2, SEG_0);
    check("mid_rst_disp3", disp3, SEG_0);
    @(negedge clock);
    check("in_rst_ack", ack, 0);
    n_reset = 1'b1;
    @(negedge clock);
    check("fresh_ack", ack, 1);
    check("fresh_disp1", disp1, 7'b1111000);
    req = 1'b0; we = 1'b0;
    @(negedge clock);
    check("fresh_ack_drop", ack, 0);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
